// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane-voltage integrator.
// Computes the Na, K and leak currents from the m/h/n gates and advances V by
// one forward-Euler step. One shared signed multiplier is stepped through the
// products by a one-state-per-cycle FSM; start/done handshake.
module hh_membrane_update #(
    parameter int G_NA     = 1920,  // mS/cm^2 x16
    parameter int G_K      = 576,   // mS/cm^2 x16
    parameter int G_L      = 5,     // mS/cm^2 x16
    parameter int E_NA     = 50,    // mV
    parameter int E_K      = -77,   // mV
    parameter int E_L      = -54,   // mV
    parameter int V_REST   = -65,   // mV
    parameter int V_MIN    = -100,  // mV
    parameter int V_MAX    = 60,    // mV
    parameter int DT_SHIFT = 4      // dt unit is 2^-DT_SHIFT ms
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [10:0]        m_in,
    input  logic [10:0]        h_in,
    input  logic [10:0]        n_in,
    input  logic signed [15:0] i_in,
    input  logic [7:0]         dt,
    output logic signed [15:0] v_out,
    output logic signed [15:0] v_mv,
    output logic               busy,
    output logic               done
);

    typedef enum logic [3:0] {
        IDLE, M2, M3, MH, GNA, INA, N2, N4, GK, IK, IL, SUM, UPD, DONE
    } state_t;

    // Reversal potentials and clamp limits in Q9.6 (1/64 mV), full datapath width.
    localparam logic signed [47:0] E_NA_Q  = 48'(E_NA * 64);
    localparam logic signed [47:0] E_K_Q   = 48'(E_K * 64);
    localparam logic signed [47:0] E_L_Q   = 48'(E_L * 64);
    localparam logic signed [47:0] V_MIN_Q = 48'(V_MIN * 64);
    localparam logic signed [47:0] V_MAX_Q = 48'(V_MAX * 64);
    localparam logic signed [15:0] V_RST_Q = 16'(V_REST * 64);

    localparam logic signed [23:0] G_NA_OP = 24'(G_NA);
    localparam logic signed [23:0] G_K_OP  = 24'(G_K);
    localparam logic signed [23:0] G_L_OP  = 24'(G_L);

    // Gates above 1.0 (1024) are treated as exactly 1.0.
    function automatic logic [10:0] sat_gate(input logic [10:0] g);
        return (g > 11'd1024) ? 11'd1024 : g;
    endfunction

    state_t state, state_next;

    // Operands captured at acceptance; the inputs are free to change afterwards.
    logic [10:0]        cap_m, cap_h, cap_n;
    logic signed [15:0] cap_i;
    logic [7:0]         cap_dt;
    logic signed [15:0] cap_v;

    // The gate chain (m2, m3, gm, gna, n2, gn, gk) and the total current never
    // exceed about 2.5e6 in magnitude, so 24 bits hold them exactly; the
    // per-ion currents keep the full 48-bit width.
    logic signed [23:0] chain;
    logic signed [47:0] ina, ik, il;
    logic signed [23:0] itot;

    logic signed [23:0] mul_a, mul_b;
    logic signed [47:0] product;
    logic signed [47:0] v_ext, i_ext, vn;
    logic signed [15:0] v_next;

    assign v_ext = 48'(cap_v);
    assign i_ext = 48'(cap_i);

    // Shared 24x24 signed multiplier; operands are sign-extended so the 48-bit
    // result is exact.
    assign product = 48'(mul_a) * 48'(mul_b);

    // Operand selection for the shared multiplier and the Euler update.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
        mul_a  = '0;
        mul_b  = '0;
        unique case (state)
            M2:      begin mul_a = {13'd0, cap_m}; mul_b = {13'd0, cap_m}; end
            M3:      begin mul_a = chain;          mul_b = {13'd0, cap_m}; end
            MH:      begin mul_a = chain;          mul_b = {13'd0, cap_h}; end
            GNA:     begin mul_a = G_NA_OP;        mul_b = chain;          end
            INA:     begin mul_a = chain;          mul_b = 24'(v_ext - E_NA_Q); end
            N2:      begin mul_a = {13'd0, cap_n}; mul_b = {13'd0, cap_n}; end
            N4:      begin mul_a = chain;          mul_b = chain;          end
            GK:      begin mul_a = G_K_OP;         mul_b = chain;          end
            IK:      begin mul_a = chain;          mul_b = 24'(v_ext - E_K_Q); end
            IL:      begin mul_a = G_L_OP;         mul_b = 24'(v_ext - E_L_Q); end
            UPD:     begin mul_a = itot;           mul_b = {16'd0, cap_dt}; end
            default: begin mul_a = '0;             mul_b = '0;             end
        endcase

        // Clamp on the full-width result, then narrow to Q9.6.
        vn = v_ext + (product >>> DT_SHIFT);
        if (vn > V_MAX_Q)
            v_next = 16'(V_MAX_Q);
        else if (vn < V_MIN_Q)
            v_next = 16'(V_MIN_Q);
        else
            v_next = 16'(vn);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state sequencing and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        unique case (state)
            IDLE:    if (start) state_next = M2;
            M2:      state_next = M3;
            M3:      state_next = MH;
            MH:      state_next = GNA;
            GNA:     state_next = INA;
            INA:     state_next = N2;
            N2:      state_next = N4;
            N4:      state_next = GK;
            GK:      state_next = IK;
            IK:      state_next = IL;
            IL:      state_next = SUM;
            SUM:     state_next = UPD;
            UPD:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture registers, intermediate results and the membrane potential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_m  <= '0;
            cap_h  <= '0;
            cap_n  <= '0;
            cap_i  <= '0;
            cap_dt <= '0;
            cap_v  <= V_RST_Q;
            chain  <= '0;
            ina    <= '0;
            ik     <= '0;
            il     <= '0;
            itot   <= '0;
            v_out  <= V_RST_Q;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    cap_m  <= sat_gate(m_in);
                    cap_h  <= sat_gate(h_in);
                    cap_n  <= sat_gate(n_in);
                    cap_i  <= i_in;
                    cap_dt <= dt;
                    cap_v  <= v_out;
                end
                M2, M3, MH, N2, N4: chain <= 24'(product >>> 10);
                GNA, GK:            chain <= 24'(product);
                INA:                ina   <= product >>> 14;
                IK:                 ik    <= product >>> 14;
                IL:                 il    <= product >>> 4;
                SUM:                itot  <= 24'(i_ext - ina - ik - il);
                UPD:                v_out <= v_next;
                default:            ;
            endcase
        end
    end

    // Integer-mV view of V (floor).
    assign v_mv = v_out >>> 6;

endmodule

// File: doc/hh_membrane_update.md
# hh_membrane_update

Sequential Hodgkin–Huxley membrane-voltage integrator. It takes the m, h and n gating variables from the gate-update blocks and computes the Na, K and leak ionic currents. It then advances the membrane potential by one forward-Euler step and drives V back to the gate blocks as `v_mv`. A single shared multiplier is time-multiplexed by an FSM, with a start/done handshake.

## Interface
Parameters:
- G_NA, 1920: Na conductance, mS/cm² ×16 (120.0)
- G_K, 576: K conductance, mS/cm² ×16 (36.0)
- G_L, 5: leak conductance, mS/cm² ×16 (≈0.3)
- E_NA, 50: Na reversal potential, integer mV
- E_K, -77: K reversal potential, integer mV
- E_L, -54: leak reversal potential, integer mV
- V_REST, -65: reset potential, integer mV
- V_MIN, -100 / V_MAX, 60: voltage clamp limits, integer mV
- DT_SHIFT, 4: dt is in units of 2^-DT_SHIFT ms

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request for one Euler step
- m_in, h_in, n_in  in  11 unsigned  gating variables, 1024 = 1.0
- i_in  in  16 signed  injected current, 1/64 µA/cm²
- dt  in  8 unsigned  time step, 2^-DT_SHIFT ms units
- v_out  out  16 signed  membrane potential, 1/64 mV (Q9.6)
- v_mv  out  16 signed  v_out >>> 6 (floor), integer mV
- busy  out  1  high whenever FSM not IDLE
- done  out  1  one-cycle pulse, step complete

## Operation
- Reset values: v_out = V_REST·64 (−4160), v_mv = V_REST (−65), busy = 0, done = 0, state = IDLE.
- Start acceptance:
  - `start` is sampled only in IDLE.
  - On acceptance, m/h/n/i_in/dt and the current v_out are captured into internal registers.
  - `start` in any other state is ignored.
  - Inputs may change freely after capture.
- Gate saturation: any gate value > 1024 is treated as 1024 at capture.
- Multiplier: one signed 24×24 → 48-bit multiplier; all intermediates are signed 48-bit.
- Shifts: all `>>>` are arithmetic (floor).
- FSM sequence, one state per cycle:
  - IDLE → M2: m2 = m·m >>> 10
  - M3: m3 = m2·m >>> 10
  - MH: gm = m3·h >>> 10
  - GNA: gna = G_NA·gm
  - INA: ina = gna·(V − E_NA·64) >>> 14
  - N2: n2 = n·n >>> 10
  - N4: gn = n2·n2 >>> 10
  - GK: gk = G_K·gn
  - IK: ik = gk·(V − E_K·64) >>> 14
  - IL: il = G_L·(V − E_L·64) >>> 4
  - SUM: itot = i_in − ina − ik − il
  - UPD: vn = V + (itot·dt >>> DT_SHIFT), clamped to [V_MIN·64, V_MAX·64]; register v_out/v_mv, done = 1
  - DONE → IDLE
- Capacitance is fixed at 1 µF/cm² (no divide).
- Clamp is applied on the full-width vn before truncation to 16 bits.
- Reset mid-operation:
  - Immediate return to IDLE with reset values.
  - No done pulse; the partial result is discarded.

## Timing
- Accept edge E0 (start high in IDLE) → state M2 and busy = 1 from E0.
- Each of the 12 states M2..UPD lasts one cycle.
- At edge E12, v_out/v_mv update and done rises; state = DONE.
- At edge E13, done falls and the FSM returns to IDLE; busy is high for cycles E0..E12 inclusive.
- Earliest next accept is edge E14, giving a 14-cycle step period.
- v_out/v_mv hold their value between done pulses; no glitching.
- start held high continuously: a new step is accepted every 14 cycles.

## Test plan
- Reset:
  - Stimulus: assert reset mid-idle.
  - Required: v_out = −4160, v_mv = −65, busy = 0, done = 0.
- Leak only:
  - Stimulus: from reset, m = h = n = 0, i_in = 0, dt = 16, one start.
  - Required: il = −220, itot = 220, v_out = −3940, v_mv = −62.
- Handshake timing:
  - Stimulus: start at E0; pulse start again at E5.
  - Required: busy high E0..E12, done high only after E12 for exactly one cycle; the second start is ignored and busy falls at E13.
- Clamp:
  - Stimulus: gates 0, dt = 255, i_in = +32767.
  - Required: v_out = 3840, v_mv = 60.
  - Stimulus: i_in = −32768 for two steps.
  - Required: v_out = −6400, v_mv = −100.
- Gate saturation:
  - Stimulus: from reset, m = h = 2047, n = 0, i_in = 0, dt = 1.
  - Required: gm = 1024, ina = −883200, itot = 883420, v_out clamps to 3840.
- Reset mid-step:
  - Stimulus: assert reset 5 cycles after accept.
  - Required: no done pulse, v_out = −4160, busy = 0; a following start behaves as the leak-only case.
